// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send,
// 8 data bits + odd parity + stop driven on device clock falls, ACK check.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wrn,
    input  logic [7:0] din,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // INHIBIT lasts one cycle less than the clock hold; the REQ cycle completes it
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;

    state_t        state;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev, wrn_q;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity, ack_ok;
    logic          fall, timed_out, watching;

    assign fall      = clk_prev & ~clk_sync[1];
    assign timed_out = (to_cnt == TO_LAST);
    assign watching  = (state == BITS) || (state == ACK) || (state == WAIT_IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            wrn_q     <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
            wrn_q     <= wrn;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            ack_ok      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (watching)
                to_cnt <= fall ? '0 : to_cnt + TW'(1);
            case (state)
                IDLE: begin
                    // falling edge of wrn only, so a held strobe sends once
                    if (!wrn && wrn_q) begin
                        shreg      <= din;
                        parity     <= ~^din;
                        bit_cnt    <= '0;
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        inh_cnt <= inh_cnt + IW'(1);
                    end
                end
                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    to_cnt     <= '0;
                    state      <= BITS;
                end
                BITS: begin
                    if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= shreg >> 1;
                        end else if (bit_cnt == 4'd8) begin
                            ps2_data_oe <= ~parity;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (fall) begin
                        ack_ok <= ~data_sync[1];
                        state  <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync[1] && data_sync[1]) begin
                        done  <= ack_ok;
                        err   <= ~ack_ok;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (watching && !fall && timed_out) begin
                state       <= IDLE;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b0;
                err         <= 1'b1;
            end
        end
    end
endmodule
